// File: rtl/timer_bus_master.sv
// timer_bus_master: turns READ/CLEAR/START/STOP host commands into timer bus cycles.
// Optional build macro TBM_COHERENT_READ_EN adds an RDCHK re-read of byte 3 that retries torn reads.
module timer_bus_master #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    ADDR_WIDTH = 8,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                  clk,
    input  logic                  rst_,
    input  logic                  cmd_valid,
    input  logic [1:0]            cmd_op,
    output logic                  cmd_ready,
    output logic [31:0]           rd_data,
    output logic                  rd_valid,
    output logic                  op_done,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic [DATA_WIDTH-1:0] bus_wdata,
    input  logic [DATA_WIDTH-1:0] bus_rdata,
    output logic                  bus_cs_,
    output logic                  bus_rw_
);
    typedef enum logic [2:0] {
        IDLE, RD0, RD1, RD2, RD3, WR, DONE
`ifdef TBM_COHERENT_READ_EN
        , RDCHK
`endif
    } state_t;

    state_t                state, nxt;
    logic [2:0]            off;
    logic                  nxt_idle, rd_done, rd3;
    logic [DATA_WIDTH-1:0] b0, b1, b2;
`ifdef TBM_COHERENT_READ_EN
    logic [DATA_WIDTH-1:0] b3;
`endif

    // next state plus the bus decode of that state, so bus outputs can be registered
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = cmd_valid ? (cmd_op == 2'd0 ? RD0 : WR) : IDLE;
            RD0:     nxt = RD1;
            RD1:     nxt = RD2;
            RD2:     nxt = RD3;
`ifdef TBM_COHERENT_READ_EN
            RD3:     nxt = RDCHK;
            RDCHK:   nxt = bus_rdata == b3 ? DONE : RD0;
`else
            RD3:     nxt = DONE;
`endif
            WR:      nxt = DONE;
            default: nxt = IDLE;
        endcase
`ifdef TBM_COHERENT_READ_EN
        rd3 = nxt == RD3 || nxt == RDCHK;
`else
        rd3 = nxt == RD3;
`endif
        off = nxt == WR ? 3'd4 : rd3 ? 3'd3 : nxt == RD2 ? 3'd2 : nxt == RD1 ? 3'd1 : 3'd0;
        nxt_idle = nxt == IDLE || nxt == DONE;
        rd_done = nxt == DONE && state != WR;
    end

    // state register and registered outputs; reset abandons any command silently
    always_ff @(posedge clk) begin
        if (!rst_) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
            op_done   <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            bus_cs_   <= 1'b1;
            bus_rw_   <= 1'b1;
        end else begin
            state     <= nxt;
            cmd_ready <= nxt == IDLE;
            op_done   <= nxt == DONE;
            rd_valid  <= rd_done;
            rd_data   <= rd_done ? {bus_rdata, b2, b1, b0} : rd_data;
            bus_cs_   <= nxt_idle;
            bus_rw_   <= nxt != WR;
            bus_addr  <= nxt_idle ? '0 : BASE_ADDR + ADDR_WIDTH'(off);
            bus_wdata <= nxt == WR ? DATA_WIDTH'(1) << (cmd_op - 2'd1) : '0;
        end
    end

    // capture each count byte at the end of its read cycle
    always_ff @(posedge clk) begin
        b0 <= state == RD0 ? bus_rdata : b0;
        b1 <= state == RD1 ? bus_rdata : b1;
        b2 <= state == RD2 ? bus_rdata : b2;
`ifdef TBM_COHERENT_READ_EN
        b3 <= state == RD3 ? bus_rdata : b3;
`endif
    end
endmodule

// File: tb/tb_timer_bus_master.sv
// tb_timer_bus_master: randomized self-checking bench with memory, timer and tearing bus models.
module tb_timer_bus_master;
    typedef logic [16:0] ent_t;

`ifdef TBM_COHERENT_READ_EN
    localparam int RD_LAT = 6;
`else
    localparam int RD_LAT = 5;
`endif

    logic        clk = 1'b0, rst_ = 1'b0, cmd_valid = 1'b0;
    logic [1:0]  cmd_op = 2'd0;
    logic        cmd_ready, rd_valid, op_done, bus_cs_, bus_rw_;
    logic [31:0] rd_data;
    logic [7:0]  bus_addr, bus_wdata, bus_rdata;

    int          tests = 0, fails = 0, cyc = 0;
    int          mode = 0, a3_cnt = 0, a3_base = 0, rv_cnt = 0, od_cnt = 0;
    logic [7:0]  mem [4];
    logic [31:0] tcount = 0, last_rd = 0;
    bit          trun = 0;
    ent_t        trace [$];

    timer_bus_master dut (
        .clk(clk), .rst_(rst_), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_ready(cmd_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .op_done(op_done), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_cs_(bus_cs_), .bus_rw_(bus_rw_)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // bus monitor, pulse counters and behavioural timer, all observed mid-cycle
    always @(negedge clk) begin
        if (!bus_cs_) trace.push_back({bus_rw_, bus_addr, bus_wdata});
        if (!bus_cs_ && bus_rw_ && bus_addr == 8'd3) a3_cnt <= a3_cnt + 1;
        rv_cnt <= rv_cnt + int'(rd_valid);
        od_cnt <= od_cnt + int'(op_done);
        if (!bus_cs_ && !bus_rw_ && bus_addr == 8'd4) begin
            tcount <= bus_wdata[0] ? 32'd0 : trun ? tcount + 1 : tcount;
            trun   <= bus_wdata[1] ? 1'b1 : bus_wdata[2] ? 1'b0 : trun;
        end else if (trun) tcount <= tcount + 1;
    end

    // peripheral read data: 0 = plain memory, 1 = timer count, 2 = byte 3 changes after its first read
    always_comb begin
        bus_rdata = 8'h00;
        if (bus_addr < 8'd4) begin
            if (mode == 1) bus_rdata = tcount[{bus_addr[1:0], 3'b000} +: 8];
            else if (mode == 2 && bus_addr == 8'd3) bus_rdata = (a3_cnt - a3_base) <= 1 ? 8'h00 : 8'h01;
            else bus_rdata = mem[bus_addr[1:0]];
        end
    end

    function automatic ent_t rd_e(input int a);
        return {1'b1, 8'(a), 8'h00};
    endfunction

    function automatic ent_t wr_e(input logic [1:0] op);
        return {1'b0, 8'h04, op == 2'd1 ? 8'h01 : op == 2'd2 ? 8'h02 : 8'h04};
    endfunction

    function automatic void push_read(inout ent_t q [$]);
        for (int i = 0; i < 4; i++) q.push_back(rd_e(i));
`ifdef TBM_COHERENT_READ_EN
        q.push_back(rd_e(3));
`endif
    endfunction

    function automatic bit trace_ok(input int s, input ent_t exp [$]);
        if (trace.size() - s != exp.size()) return 1'b0;
        foreach (exp[i]) if (trace[s + i] !== exp[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [31:0] mem_word();
        return {mem[3], mem[2], mem[1], mem[0]};
    endfunction

    task automatic wait_ready();
        for (int i = 0; i < 50 && !cmd_ready; i++) @(negedge clk);
    endtask

    task automatic issue(input logic [1:0] op, output int acc, output int lat, output bit to);
        acc = 0;
        lat = 0;
        wait_ready();
        to = !cmd_ready;
        if (to) return;
        cmd_valid = 1'b1;
        cmd_op = op;
        @(negedge clk);
        cmd_valid = 1'b0;
        acc = cyc;
        lat = 1;
        while (lat < 40 && !op_done) begin
            @(negedge clk);
            lat++;
        end
        to = !op_done;
    endtask

    task automatic test_reset();
        rst_ = 1'b0;
        repeat (3) @(negedge clk);
        rst_ = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tests++;
            if ({bus_cs_, bus_rw_, bus_addr, bus_wdata, cmd_ready, rd_valid, op_done, rd_data} !==
                {1'b1, 1'b1, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 32'h0}) begin
                fails++;
                $display("FAIL reset_idle cyc%0d: cs_=%b rw_=%b addr=%h wdata=%h rdy=%b rv=%b done=%b rd=%h, want 1 1 00 00 1 0 0 00000000",
                         i, bus_cs_, bus_rw_, bus_addr, bus_wdata, cmd_ready, rd_valid, op_done, rd_data);
            end
        end
        tests++;
        if (trace.size() != 0) begin
            fails++;
            $display("FAIL reset_bus_quiet: %0d bus cycles seen, want 0", trace.size());
        end
    endtask

    task automatic test_read(input int n);
        int acc, lat, s, rv0, od0;
        bit to;
        ent_t exp [$];
        for (int it = 0; it < n; it++) begin
            mode = 0;
            if (it == 0) begin
                mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
            end else for (int i = 0; i < 4; i++) mem[i] = 8'($urandom);
            s = trace.size(); rv0 = rv_cnt; od0 = od_cnt;
            exp.delete();
            push_read(exp);
            issue(2'd0, acc, lat, to);
            last_rd = mem_word();
            tests++;
            if (to || lat != RD_LAT) begin
                fails++;
                $display("FAIL read_latency: got %0d (timeout=%0b), want %0d", lat, to, RD_LAT);
            end
            tests++;
            if (rd_data !== last_rd || rd_valid !== 1'b1) begin
                fails++;
                $display("FAIL read_data: got %h valid=%b, want %h valid=1", rd_data, rd_valid, last_rd);
            end
            @(negedge clk);
            tests++;
            if (rv_cnt - rv0 != 1 || od_cnt - od0 != 1 || rd_valid !== 1'b0) begin
                fails++;
                $display("FAIL read_pulses: rd_valid x%0d op_done x%0d now rv=%b, want 1 1 0", rv_cnt - rv0, od_cnt - od0, rd_valid);
            end
            tests++;
            if (!trace_ok(s, exp)) begin
                fails++;
                $display("FAIL read_trace: got %0d bus cycles, want %0d (or contents differ)", trace.size() - s, exp.size());
            end
        end
    endtask

    task automatic test_write_timer();
        int acc [3], lat [3], s, a, l;
        bit to [3], t;
        ent_t exp [$];
        mode = 1;
        s = trace.size();
        for (int i = 0; i < 3; i++) begin
            issue(2'(i + 1), acc[i], lat[i], to[i]);
            exp.push_back(wr_e(2'(i + 1)));
        end
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (to[i] || lat[i] != 2) begin
                fails++;
                $display("FAIL write_latency op%0d: got %0d (timeout=%0b), want 2", i + 1, lat[i], to[i]);
            end
        end
        for (int i = 1; i < 3; i++) begin
            tests++;
            if (acc[i] - acc[i - 1] != 3) begin
                fails++;
                $display("FAIL write_spacing %0d: got %0d cycles, want 3", i, acc[i] - acc[i - 1]);
            end
        end
        @(negedge clk);
        tests++;
        if (!trace_ok(s, exp)) begin
            fails++;
            $display("FAIL write_trace: got %0d bus cycles, want %0d (or contents differ)", trace.size() - s, exp.size());
        end
        tests++;
        if (rd_data !== last_rd) begin
            fails++;
            $display("FAIL rd_data_hold: got %h, want %h", rd_data, last_rd);
        end
        issue(2'd0, a, l, t);
        last_rd = 32'(acc[2] - acc[1]);
        tests++;
        if (t || rd_data !== last_rd) begin
            fails++;
            $display("FAIL timer_read: got %h (timeout=%0b), want %h", rd_data, t, last_rd);
        end
    endtask

    task automatic test_reset_mid_read();
        int s, rv0, od0;
        ent_t exp [$];
        mode = 0;
        for (int i = 0; i < 4; i++) mem[i] = 8'($urandom);
        wait_ready();
        s = trace.size(); rv0 = rv_cnt; od0 = od_cnt;
        cmd_valid = 1'b1;
        cmd_op = 2'd0;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_ = 1'b0;
        @(negedge clk);
        tests++;
        if ({bus_cs_, bus_rw_, bus_addr, cmd_ready, rd_valid, op_done, rd_data} !==
            {1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 32'h0}) begin
            fails++;
            $display("FAIL midread_reset: cs_=%b rw_=%b addr=%h rdy=%b rv=%b done=%b rd=%h, want 1 1 00 1 0 0 00000000",
                     bus_cs_, bus_rw_, bus_addr, cmd_ready, rd_valid, op_done, rd_data);
        end
        rst_ = 1'b1;
        repeat (6) @(negedge clk);
        last_rd = 32'h0;
        for (int i = 0; i < 3; i++) exp.push_back(rd_e(i));
        tests++;
        if (!trace_ok(s, exp)) begin
            fails++;
            $display("FAIL midread_trace: got %0d bus cycles, want 3 (or contents differ)", trace.size() - s);
        end
        tests++;
        if (rv_cnt != rv0 || od_cnt != od0 || rd_data !== 32'h0 || cmd_ready !== 1'b1) begin
            fails++;
            $display("FAIL midread_after: rv x%0d done x%0d rd=%h rdy=%b, want 0 0 00000000 1",
                     rv_cnt - rv0, od_cnt - od0, rd_data, cmd_ready);
        end
    endtask

    task automatic test_tear();
        int acc, lat, s, rv0, want_lat;
        bit to;
        ent_t exp [$];
        logic [7:0] b3;
        mode = 2;
        for (int i = 0; i < 3; i++) mem[i] = 8'($urandom);
        wait_ready();
        a3_base = a3_cnt;
        s = trace.size(); rv0 = rv_cnt;
        push_read(exp);
`ifdef TBM_COHERENT_READ_EN
        push_read(exp);
        want_lat = 2 * RD_LAT - 1;
        b3 = 8'h01;
`else
        want_lat = RD_LAT;
        b3 = 8'h00;
`endif
        issue(2'd0, acc, lat, to);
        last_rd = {b3, mem[2], mem[1], mem[0]};
        tests++;
        if (to || lat != want_lat || rd_data !== last_rd) begin
            fails++;
            $display("FAIL tear_read: lat=%0d rd=%h (timeout=%0b), want lat=%0d rd=%h", lat, rd_data, to, want_lat, last_rd);
        end
        @(negedge clk);
        tests++;
        if (rv_cnt - rv0 != 1 || !trace_ok(s, exp)) begin
            fails++;
            $display("FAIL tear_trace: rd_valid x%0d, %0d bus cycles, want 1 and %0d", rv_cnt - rv0, trace.size() - s, exp.size());
        end
    endtask

    task automatic test_held_cmd();
        int s, rv0, od0;
        ent_t exp [$];
        mode = 0;
        for (int i = 0; i < 4; i++) mem[i] = 8'($urandom);
        wait_ready();
        s = trace.size(); rv0 = rv_cnt; od0 = od_cnt;
        push_read(exp);
        cmd_valid = 1'b1;
        cmd_op = 2'd0;
        @(negedge clk);
        for (int i = 0; i < 20 && !op_done; i++) begin
            cmd_op = 2'($urandom_range(0, 3));
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        repeat (4) @(negedge clk);
        last_rd = mem_word();
        tests++;
        if (!trace_ok(s, exp) || od_cnt - od0 != 1 || rv_cnt - rv0 != 1) begin
            fails++;
            $display("FAIL held_cmd: %0d bus cycles, op_done x%0d, rd_valid x%0d, want %0d 1 1",
                     trace.size() - s, od_cnt - od0, rv_cnt - rv0, exp.size());
        end
        tests++;
        if (rd_data !== last_rd) begin
            fails++;
            $display("FAIL held_cmd_data: got %h, want %h", rd_data, last_rd);
        end
    endtask

    task automatic test_back_to_back(input int n);
        int acc, prev_acc, lat, s, want_gap;
        bit to;
        logic [1:0] op, prev_op;
        ent_t exp [$];
        mode = 0;
        for (int i = 0; i < 4; i++) mem[i] = 8'($urandom);
        s = trace.size();
        prev_acc = 0;
        prev_op = 2'd0;
        for (int i = 0; i < n; i++) begin
            op = 2'($urandom_range(0, 3));
            if (op == 2'd0) begin
                push_read(exp);
                last_rd = mem_word();
            end else exp.push_back(wr_e(op));
            issue(op, acc, lat, to);
            tests++;
            if (to || lat != (op == 2'd0 ? RD_LAT : 2)) begin
                fails++;
                $display("FAIL b2b_latency #%0d op%0d: got %0d (timeout=%0b), want %0d", i, op, lat, to, op == 2'd0 ? RD_LAT : 2);
            end
            want_gap = prev_op == 2'd0 ? RD_LAT + 1 : 3;
            if (i > 0) begin
                tests++;
                if (acc - prev_acc != want_gap) begin
                    fails++;
                    $display("FAIL b2b_spacing #%0d: got %0d cycles, want %0d", i, acc - prev_acc, want_gap);
                end
            end
            prev_acc = acc;
            prev_op = op;
        end
        @(negedge clk);
        tests++;
        if (!trace_ok(s, exp) || rd_data !== last_rd) begin
            fails++;
            $display("FAIL b2b_result: %0d bus cycles rd=%h, want %0d rd=%h", trace.size() - s, rd_data, exp.size(), last_rd);
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) mem[i] = 8'h00;
        test_reset();
        test_read(6);
        test_write_timer();
        test_reset_mid_read();
        test_tear();
        test_held_cmd();
        test_back_to_back(12);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, %0d tests run, %0d failed", tests, fails);
        $fatal(1);
    end
endmodule
